// File: rtl/mmix_mem_pkg.sv
// rtl/mmix_mem_pkg.sv - shared types and lane helpers for the MMIX memory responder
// Contents: size_e (access size), state_e (responder FSM states),
//           lane_be (byte enables), align (size alignment), extract (read lane pick).
package mmix_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WYDE  = 2'd1,
        SZ_TETRA = 2'd2,
        SZ_OCTA  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Big-endian lanes: byte offset k lives in lane 3-k, be[3] = bits 31:24.
    function automatic logic [3:0] lane_be(size_e size, logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> a;
            SZ_WYDE: be = a[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [63:0] align(logic [63:0] addr, size_e size);
        return addr & ~((64'd1 << size) - 64'd1);
    endfunction

    // Pull the addressed lanes out of a tetra, right-justified and zero-extended.
    function automatic logic [31:0] extract(logic [31:0] rdata, size_e size, logic [1:0] a);
        logic [31:0] v;
        logic [4:0]  sh;
        sh = {~a, 3'b000};  // (3 - a) * 8
        case (size)
            SZ_BYTE: v = (rdata >> sh) & 32'h0000_00FF;
            SZ_WYDE: v = a[1] ? {16'h0000, rdata[15:0]} : {16'h0000, rdata[31:16]};
            default: v = rdata;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mmix_mem_responder_if.sv
// rtl/mmix_mem_responder_if.sv - CPU-side size-tagged request/done memory bus
// Signals: mem_address, mem_datasize, mem_read, mem_write, mem_writedata (CPU -> memory),
//          mem_readdata, mem_done (memory -> CPU).
// Modports: master = CPU side, slave = responder side.
interface mmix_mem_responder_if;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;

    modport master (
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done
    );

    modport slave (
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done
    );
endinterface

// File: rtl/mmix_lane_align.sv
// rtl/mmix_lane_align.sv - combinational lane steering between the 64-bit bus and a 32-bit RAM
// Ports: size, offset (latched address bits 1:0), beat (octa half, 0 = high tetra),
//        writedata (latched, right-justified), rdata (RAM tetra) ->
//        be (byte enables), wdata (replicated RAM write data), rd_value (extracted read lanes).
module mmix_lane_align
    import mmix_mem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        beat,
    input  logic [63:0] writedata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd_value
);

    always_comb begin
        be       = lane_be(size, offset);
        rd_value = extract(rdata, size, offset);
        // Replicating the value means the enabled lanes always carry it,
        // whatever the offset.
        case (size)
            SZ_BYTE:  wdata = {4{writedata[7:0]}};
            SZ_WYDE:  wdata = {2{writedata[15:0]}};
            SZ_TETRA: wdata = writedata[31:0];
            default:  wdata = beat ? writedata[31:0] : writedata[63:32];
        endcase
    end

endmodule

// File: rtl/mmix_mem_responder.sv
// rtl/mmix_mem_responder.sv - responder servicing MMIX bus requests against a 32-bit big-endian RAM
// Ports: clk, reset (async, active-high); bus (slave side of the CPU request/done bus);
//        ram_addr/ram_re/ram_we/ram_be/ram_wdata -> RAM, ram_rdata <- RAM;
//        protocol_err (sticky: read and write requested together).
module mmix_mem_responder
    import mmix_mem_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mmix_mem_responder_if.slave  bus,
    output logic [ADDR_BITS-3:0] ram_addr,
    output logic                 ram_re,
    output logic                 ram_we,
    output logic [3:0]           ram_be,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata,
    output logic                 protocol_err
);

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_e                 state, state_d;
    logic [ADDR_BITS-1:0]   addr_q;
    size_e                  size_q;
    logic [63:0]            wdata_q;
    logic                   is_write_q;
    logic                   beat_q;
    logic [1:0]             cnt_q;
    logic [63:0]            readdata_q;
    logic                   perr_q;

    logic                   req;
    size_e                  req_size;
    logic [63:0]            aligned_addr;
    logic                   more_beats;
    logic [ADDR_BITS-3:0]   tetra_addr;
    logic [3:0]             lane_be_w;
    logic [31:0]            lane_wdata;
    logic [31:0]            rd_value;

    assign req          = bus.mem_read | bus.mem_write;
    assign req_size     = size_e'(bus.mem_datasize);
    assign aligned_addr = align(bus.mem_address, req_size);
    assign more_beats   = (size_q == SZ_OCTA) && !beat_q;
    // Octa addresses are 8-aligned, so beat1 just sets bit 0 of the tetra index;
    // the top bits never carry, which gives the required wrap at the top of memory.
    assign tetra_addr   = addr_q[ADDR_BITS-1:2] | {{(ADDR_BITS-3){1'b0}}, beat_q};

    mmix_lane_align u_lane (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .beat      (beat_q),
        .writedata (wdata_q),
        .rdata     (ram_rdata),
        .be        (lane_be_w),
        .wdata     (lane_wdata),
        .rd_value  (rd_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d      = state;
        ram_re       = 1'b0;
        ram_we       = 1'b0;
        ram_be       = 4'b0000;
        ram_wdata    = 32'h0;
        bus.mem_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                ram_be = lane_be_w;
                if (is_write_q) begin
                    ram_we    = 1'b1;
                    ram_wdata = lane_wdata;
                    state_d   = more_beats ? ST_ISSUE : ST_DONE;
                end else begin
                    ram_re  = 1'b1;
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (cnt_q == 2'd0) state_d = more_beats ? ST_ISSUE : ST_DONE;
            end
            default: begin
                bus.mem_done = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            beat_q     <= 1'b0;
            cnt_q      <= '0;
            readdata_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q     <= aligned_addr[ADDR_BITS-1:0];
                        size_q     <= req_size;
                        wdata_q    <= bus.mem_writedata;
                        // Read wins when both are raised; the write is dropped.
                        is_write_q <= !bus.mem_read;
                        beat_q     <= 1'b0;
                        if (bus.mem_read && bus.mem_write) perr_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= LAT_M1;
                    // Reads keep beat_q until the data is captured in RWAIT.
                    if (is_write_q && more_beats) beat_q <= 1'b1;
                end
                ST_RWAIT: begin
                    if (cnt_q == 2'd0) begin
                        if (size_q == SZ_OCTA) begin
                            if (beat_q) readdata_q[31:0]  <= ram_rdata;
                            else        readdata_q[63:32] <= ram_rdata;
                        end else begin
                            readdata_q <= {32'h0, rd_value};
                        end
                        if (more_beats) beat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr         = (state == ST_ISSUE) ? tetra_addr : '0;
    assign bus.mem_readdata = readdata_q;
    assign protocol_err     = perr_q;

endmodule

// File: tb/tb_mmix_mem_responder.sv
// tb/tb_mmix_mem_responder.sv - bench for mmix_mem_responder at RD_LAT 1 and 3
module tb_mmix_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [63:0] d_addr;
    logic [1:0]  d_size;
    logic        d_read, d_write;
    logic [63:0] d_wdata;

    always #5 clk = ~clk;

    mmix_mem_responder_if b1 ();
    mmix_mem_responder_if b3 ();

    assign b1.mem_address   = d_addr;
    assign b1.mem_datasize  = d_size;
    assign b1.mem_writedata = d_wdata;
    assign b1.mem_read      = d_read & ~sel;
    assign b1.mem_write     = d_write & ~sel;
    assign b3.mem_address   = d_addr;
    assign b3.mem_datasize  = d_size;
    assign b3.mem_writedata = d_wdata;
    assign b3.mem_read      = d_read & sel;
    assign b3.mem_write     = d_write & sel;

    logic [13:0] ra1, ra3;
    logic        re1, re3, we1, we3, pe1, pe3;
    logic [3:0]  be1, be3;
    logic [31:0] wd1, wd3, rd1, rd3;

    mmix_mem_responder #(.ADDR_BITS(16), .RD_LAT(1)) u1 (
        .clk(clk), .reset(rst), .bus(b1), .ram_addr(ra1), .ram_re(re1), .ram_we(we1),
        .ram_be(be1), .ram_wdata(wd1), .ram_rdata(rd1), .protocol_err(pe1));

    mmix_mem_responder #(.ADDR_BITS(16), .RD_LAT(3)) u3 (
        .clk(clk), .reset(rst), .bus(b3), .ram_addr(ra3), .ram_re(re3), .ram_we(we3),
        .ram_be(be3), .ram_wdata(wd3), .ram_rdata(rd3), .protocol_err(pe3));

    // Shared RAM image; two read pipelines model the two latencies.
    logic [31:0] ram [0:16383];
    logic [31:0] p1, p3a, p3b, p3c;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (we1) ram[ra1] <= merge(ram[ra1], wd1, be1);
        if (we3) ram[ra3] <= merge(ram[ra3], wd3, be3);
        if (re1) p1  <= ram[ra1];
        if (re3) p3a <= ram[ra3];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rd1 = p1;
    assign rd3 = p3c;

    wire         m_done  = sel ? b3.mem_done : b1.mem_done;
    wire  [63:0] m_rdata = sel ? b3.mem_readdata : b1.mem_readdata;
    wire         m_re    = sel ? re3 : re1;
    wire         m_we    = sel ? we3 : we1;
    wire  [13:0] m_addr  = sel ? ra3 : ra1;
    wire  [3:0]  m_be    = sel ? be3 : be1;
    wire  [31:0] m_wd    = sel ? wd3 : wd1;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          nchk = 0;
    int          nerr = 0;
    int          re_cyc;
    int          done_cyc;
    logic [13:0] wl_addr[$];
    logic [3:0]  wl_be[$];
    logic [31:0] wl_wd[$];
    int          wl_n[$];
    bit          saw_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, log RAM activity per cycle, then score the completion.
    task automatic req(input bit s, input bit rd, input bit wr, input logic [63:0] a,
                       input logic [1:0] sz, input logic [63:0] wd,
                       input logic [63:0] exp_data, input int exp_cyc,
                       input string tag, input bit glitch);
        exp_t e;
        int   n;
        e.data = exp_data;
        e.cyc  = exp_cyc;
        sbq.push_back(e);
        @(negedge clk);
        sel = s; d_addr = a; d_size = sz; d_wdata = wd; d_read = rd; d_write = wr;
        n = 0; re_cyc = -1; done_cyc = -1;
        wl_addr.delete(); wl_be.delete(); wl_wd.delete(); wl_n.delete();
        while (done_cyc < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (m_re && re_cyc < 0) re_cyc = n;
            if (m_we) begin
                wl_addr.push_back(m_addr); wl_be.push_back(m_be);
                wl_wd.push_back(m_wd);     wl_n.push_back(n);
            end
            if (m_done) done_cyc = n;
            if (glitch && n == 2) d_addr = ~a;
        end
        d_read = 1'b0; d_write = 1'b0;
        e = sbq.pop_front();
        chk({tag, " done cycle"}, 64'(done_cyc), 64'(e.cyc));
        chk({tag, " readdata"}, m_rdata, e.data);
        @(negedge clk);
        chk({tag, " done one cycle"}, 64'(m_done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[14'h0040] = 32'h89AB_CDEF;
        ram[14'h00C0] = 32'h1122_3344;
        ram[14'h0140] = 32'hDEAD_BEEF;
        ram[14'h3FFE] = 32'hCAFE_F00D;
        ram[14'h3FFF] = 32'h1234_5678;
        p1 = '0; p3a = '0; p3b = '0; p3c = '0;
        rst = 1'b1; sel = 1'b0; d_addr = '0; d_size = 2'd0;
        d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset readdata", b1.mem_readdata, 64'h0);
        chk("reset done", {62'h0, b1.mem_done, b3.mem_done}, 64'h0);
        chk("reset strobes", {60'h0, re1, we1, re3, we3}, 64'h0);
        chk("reset perr", {62'h0, pe1, pe3}, 64'h0);
        rst = 1'b0;

        req(0, 1, 0, 64'h101, 2'd0, 64'h0, 64'hAB, 3, "byte read", 0);
        chk("byte read re cycle", 64'(re_cyc), 64'd1);
        chk("byte read no we", 64'(wl_n.size()), 64'd0);

        req(0, 0, 1, 64'h20D, 2'd3, 64'h0123_4567_89AB_CDEF, 64'hAB, 3, "octa write", 0);
        chk("octa write beats", 64'(wl_n.size()), 64'd2);
        if (wl_n.size() == 2) begin
            chk("octa w0 addr", 64'(wl_addr[0]), 64'h82);
            chk("octa w0 data", 64'(wl_wd[0]), 64'h0123_4567);
            chk("octa w0 be", 64'(wl_be[0]), 64'hF);
            chk("octa w0 cycle", 64'(wl_n[0]), 64'd1);
            chk("octa w1 addr", 64'(wl_addr[1]), 64'h83);
            chk("octa w1 data", 64'(wl_wd[1]), 64'h89AB_CDEF);
            chk("octa w1 be", 64'(wl_be[1]), 64'hF);
        end

        req(0, 1, 0, 64'h208, 2'd3, 64'h0, 64'h0123_4567_89AB_CDEF, 5, "octa read", 0);

        req(0, 0, 1, 64'h303, 2'd1, 64'hBEEF, 64'h0123_4567_89AB_CDEF, 2, "wyde write", 0);
        chk("wyde write beats", 64'(wl_n.size()), 64'd1);
        if (wl_n.size() == 1) begin
            chk("wyde be", 64'(wl_be[0]), 64'h3);
            chk("wyde addr", 64'(wl_addr[0]), 64'hC0);
            chk("wyde data", 64'(wl_wd[0][15:0]), 64'hBEEF);
        end
        req(0, 1, 0, 64'h300, 2'd2, 64'h0, 64'h1122_BEEF, 3, "wyde readback", 0);

        req(1, 1, 0, 64'h500, 2'd2, 64'h0, 64'hDEAD_BEEF, 5, "lat3 tetra", 1);
        req(1, 1, 0, 64'h208, 2'd3, 64'h0, 64'h0123_4567_89AB_CDEF, 9, "lat3 octa", 0);

        req(0, 1, 0, 64'hABCD_0000_0000_FFFB, 2'd3, 64'h0, 64'hCAFE_F00D_1234_5678, 5, "wrap octa", 0);

        req(0, 1, 1, 64'h100, 2'd2, 64'hFFFF_FFFF, 64'h89AB_CDEF, 3, "rd+wr", 0);
        chk("rd+wr no we", 64'(wl_n.size()), 64'd0);
        chk("rd+wr perr", 64'(pe1), 64'd1);
        req(0, 0, 1, 64'h102, 2'd0, 64'h55, 64'h89AB_CDEF, 2, "byte write", 0);
        chk("byte write be", (wl_n.size() == 1) ? 64'(wl_be[0]) : 64'hFF, 64'h2);
        chk("perr sticky", 64'(pe1), 64'd1);

        // Reset during RWAIT of an octa read on the RD_LAT=1 responder.
        @(negedge clk);
        sel = 1'b0; d_addr = 64'h208; d_size = 2'd3; d_read = 1'b1; d_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort readdata", b1.mem_readdata, 64'h0);
        chk("abort outputs", {55'h0, b1.mem_done, re1, we1, be1, pe1}, 64'h0);
        chk("abort ram_addr", 64'(ra1), 64'h0);
        d_read = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (b1.mem_done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (b1.mem_done) saw_done = 1'b1;
        end
        chk("abort no done", 64'(saw_done), 64'd0);
        req(0, 1, 0, 64'h102, 2'd0, 64'h0, 64'h55, 3, "post-reset byte", 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mmix_mem_responder.md
Name: mmix_mem_responder

Overview:
Memory-side responder for the CPU's size-tagged request/done memory bus.
- Accepts one read or write at a time on mem_address/mem_datasize/mem_read/mem_write.
- Services it against a 32-bit big-endian synchronous RAM with byte enables.
- Returns right-justified read data and a one-cycle mem_done pulse.
- Sits between the CPU (fetch and exec units share the bus) and on-chip block RAM.

Parameters:
- ADDR_BITS, 16: number of byte-address bits decoded; higher address bits are ignored, so addresses wrap modulo 2^ADDR_BITS.
- RD_LAT, 1: RAM edges from the edge that samples ram_re to the cycle in which ram_rdata is valid (1 to 3).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_address  in  64  byte address; held stable while a request is pending.
- mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa.
- mem_read  in  1  read request level; held until mem_done.
- mem_write  in  1  write request level; held until mem_done.
- mem_writedata  in  64  write value, right-justified.
- mem_readdata  out  64  read result, right-justified, zero-extended.
- mem_done  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_BITS-2  tetra address.
- ram_re  out  1  RAM read strobe.
- ram_we  out  1  RAM write strobe.
- ram_be  out  4  byte enables; be[3] selects bits 31:24.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.
- protocol_err  out  1  sticky flag: mem_read and mem_write were seen together.

Behaviour:
Reset values: all outputs 0, state IDLE. Reset mid-transaction aborts it with no done pulse; a RAM write already issued is not undone.

Addressing and alignment:
- Address a is forced to size alignment: a & ~(2^size - 1).
- Octa: beat0 = high tetra at a&~7, beat1 = low tetra at (a&~7)+4.
- Big-endian lanes: byte offset k within a tetra maps to lane 3-k.
- Wyde at offset 0 uses be=1100; at offset 2, be=0011.
- Tetra and octa beats use be=1111.
- Write data is replicated into the selected lanes. Read data is extracted from the lanes, zero-extended, and merged; octa is {beat0, beat1}.

State machine: IDLE -> ISSUE -> RWAIT -> (ISSUE for octa beat1) -> DONE -> IDLE.
- IDLE: samples a request at a clock edge and latches address, size and writedata. Later changes on those inputs are ignored until DONE.
- ISSUE: read drives ram_re=1 for one cycle; write drives ram_we=1 with be and wdata.
- Writes skip RWAIT. An octa write issues beat1 in the next cycle.
- RWAIT: counts RD_LAT cycles, then captures ram_rdata into the corresponding half of mem_readdata.
- DONE: mem_done=1 for exactly one cycle, then IDLE.
- A request held high in the cycle after DONE is treated as a new request.

Latency, counting request-sampled cycle as 0:
- Single-beat read: done in cycle 2+RD_LAT.
- Octa read: done in cycle 2*(RD_LAT+1)+1.
- Write: done in cycle 2; octa write done in cycle 3.

Other rules:
- mem_readdata holds its last value until the next read completes. Writes leave it unchanged.
- Read and write asserted together: read is serviced, write ignored, protocol_err set until reset.
- Wrap-around: octa at 2^ADDR_BITS-8 uses tetras at the top of memory; there is no carry beyond ADDR_BITS.

Decomposition:
- Package mmix_mem_pkg holds: size enum (SZ_BYTE, SZ_WYDE, SZ_TETRA, SZ_OCTA), state enum, and functions lane_be(size, a[1:0]), align(addr, size) and extract(rdata, size, a[1:0]).
- One sub-module is natural: mmix_lane_align. It is combinational, generating be/wdata and the extracted read value.
- The FSM and counter stay in mmix_mem_responder.

Test Plan:
- RAM tetra at 0x100 = 0x89ABCDEF, RD_LAT=1; byte read at 0x101 -> ram_re in cycle 1, mem_readdata=0xAB, mem_done in cycle 3 only.
- Octa write of 0x0123456789ABCDEF to 0x20D -> two beats: 0x208 with 0x01234567, then 0x20C with 0x89ABCDEF; be=1111; done in cycle 3. An octa read of 0x208 then returns the same value, done in cycle 5.
- Wyde write of 0xBEEF at 0x303 -> be=0011 at tetra 0x300, ram_wdata[15:0]=0xBEEF; other bytes keep their prior value on readback.
- RD_LAT=3 tetra read -> done exactly in cycle 5. Changing mem_address in cycle 2 does not alter the result.
- mem_read and mem_write asserted together -> read performed, no ram_we, protocol_err=1 and stays 1.
- Reset asserted in RWAIT of an octa read -> outputs 0 immediately, no mem_done. A new byte read after release completes normally.
